// File: rtl/fetch_ifid_stage_if.sv
// Instruction-memory request/response bundle between the fetch stage and imem.
//   addr   : fetch address (current PC)
//   req    : fetch request, high whenever the fetch stage is out of reset
//   ready  : rdata is valid for addr in this cycle
//   rdata  : fetched instruction word
// master = fetch stage, slave = instruction memory.
interface fetch_ifid_stage_if;
    logic [31:0] addr;
    logic        req;
    logic        ready;
    logic [31:0] rdata;

    modport master (
        output addr,
        output req,
        input  ready,
        input  rdata
    );

    modport slave (
        input  addr,
        input  req,
        output ready,
        output rdata
    );
endinterface

// File: rtl/fetch_ifid_stage.sv
// Instruction-fetch stage plus IF/ID pipeline register of a 5-stage MIPS pipeline.
// Owns the PC, issues instruction-memory requests and captures the fetched
// instruction together with its PC+4 into IF/ID.
// Ports:
//   clk, reset       : single clock, synchronous active-high reset
//   s1               : data-hazard stall level (0 = stall, holds IF/ID)
//   s2               : control-hazard stall level (0 = stall, inserts NOP)
//   redirect_valid   : branch taken / jump resolved, load redirect_target
//   redirect_target  : new PC on redirect (used unaligned as given)
//   imem             : instruction-memory bundle (addr/req out, ready/rdata in)
//   if_instr         : IF/ID instruction (0 = NOP/bubble)
//   if_pc4           : IF/ID PC+4 of if_instr
//   if_valid         : if_instr is a real fetched instruction
//   stall_cnt        : saturating count of cycles with s1=0 or s2=0
//   bubble_cnt       : saturating count of NOPs inserted into IF/ID
module fetch_ifid_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 s1,
    input  logic                 s2,
    input  logic                 redirect_valid,
    input  logic [31:0]          redirect_target,
    fetch_ifid_stage_if.master   imem,
    output logic [31:0]          if_instr,
    output logic [31:0]          if_pc4,
    output logic                 if_valid,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     bubble_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    logic [31:0]      pc_p0, pc_nxt, pc_plus4;
    logic [31:0]      instr_p1, instr_nxt;
    logic [31:0]      pc4_p1, pc4_nxt;
    logic             vld_p1, vld_nxt;
    logic [CNT_W-1:0] stall_cnt_q, bubble_cnt_q;
    logic             bubble_inc, stall_inc;

    // ---- stage 0: PC / fetch request ----
    assign pc_plus4  = pc_p0 + 32'd4;   // wraps modulo 2^32
    assign imem.addr = pc_p0;
    assign imem.req  = ~reset;
    assign stall_inc = ~s1 | ~s2;

    // Priority: redirect > data stall (hold) > control stall / memory wait (bubble) > advance.
    // The PC advances only on the cycle its instruction is captured, so nothing is lost or repeated.
    always_comb begin
        pc_nxt     = pc_p0;
        instr_nxt  = instr_p1;
        pc4_nxt    = pc4_p1;
        vld_nxt    = vld_p1;
        bubble_inc = 1'b0;
        if (redirect_valid) begin
            pc_nxt     = redirect_target;
            instr_nxt  = 32'd0;
            pc4_nxt    = 32'd0;
            vld_nxt    = 1'b0;
            bubble_inc = 1'b1;
        end else if (!s1) begin
            // decode keeps its instruction; nothing changes
        end else if (!s2 || !imem.ready) begin
            instr_nxt  = 32'd0;
            pc4_nxt    = 32'd0;
            vld_nxt    = 1'b0;
            bubble_inc = 1'b1;
        end else begin
            pc_nxt    = pc_plus4;
            instr_nxt = imem.rdata;
            pc4_nxt   = pc_plus4;
            vld_nxt   = 1'b1;
        end
    end

    // ---- stage 1: IF/ID register and performance counters ----
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_p0        <= RESET_PC;
            instr_p1     <= 32'd0;
            pc4_p1       <= 32'd0;
            vld_p1       <= 1'b0;
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            pc_p0    <= pc_nxt;
            instr_p1 <= instr_nxt;
            pc4_p1   <= pc4_nxt;
            vld_p1   <= vld_nxt;
            if (stall_inc)  stall_cnt_q  <= sat_inc(stall_cnt_q);
            if (bubble_inc) bubble_cnt_q <= sat_inc(bubble_cnt_q);
        end
    end

    assign if_instr   = instr_p1;
    assign if_pc4     = pc4_p1;
    assign if_valid   = vld_p1;
    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_fetch_ifid_stage.sv
// Self-checking bench for fetch_ifid_stage. A reference model advances one
// cycle per stimulus step, pushes its expected post-edge state to a queue and
// the entry is popped and compared once the DUT has clocked.
module tb_fetch_ifid_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int unsigned CNT_W    = 4;
    localparam logic [CNT_W-1:0] CMAX = {CNT_W{1'b1}};

    logic             clk = 1'b0;
    logic             reset, s1, s2, redirect_valid, rdy;
    logic [31:0]      redirect_target;
    logic [31:0]      if_instr, if_pc4;
    logic             if_valid;
    logic [CNT_W-1:0] stall_cnt, bubble_cnt;

    int tests  = 0;
    int failed = 0;

    typedef struct {
        logic [31:0]      pc;
        logic [31:0]      instr;
        logic [31:0]      pc4;
        logic             valid;
        logic [CNT_W-1:0] stall;
        logic [CNT_W-1:0] bubble;
    } exp_t;

    exp_t sb[$];

    logic [31:0]      m_pc = RESET_PC;
    logic [31:0]      m_instr = 32'd0, m_pc4 = 32'd0;
    logic             m_valid = 1'b0;
    logic [CNT_W-1:0] m_stall = '0, m_bubble = '0;

    fetch_ifid_stage_if imem_bus();

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[7:0], a[31:8]} ^ 32'h8C3A_51E7;
    endfunction

    assign imem_bus.ready = rdy;
    assign imem_bus.rdata = mem_word(imem_bus.addr);

    fetch_ifid_stage #(.RESET_PC(RESET_PC), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .reset           (reset),
        .s1              (s1),
        .s2              (s2),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .imem            (imem_bus),
        .if_instr        (if_instr),
        .if_pc4          (if_pc4),
        .if_valid        (if_valid),
        .stall_cnt       (stall_cnt),
        .bubble_cnt      (bubble_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [CNT_W-1:0] sat(input logic [CNT_W-1:0] v);
        return (v == CMAX) ? v : v + 1'b1;
    endfunction

    // One clock of stimulus; called just after a rising edge.
    task automatic step(input logic r, input logic a1, input logic a2,
                        input logic rv, input logic [31:0] rt, input logic rd);
        exp_t e;
        reset = r; s1 = a1; s2 = a2; redirect_valid = rv; redirect_target = rt; rdy = rd;
        #1;
        tests++;
        if (imem_bus.req !== ~r) begin
            failed++;
            $display("FAIL imem_req: got %b expected %b", imem_bus.req, ~r);
        end
        if (!r) begin
            tests++;
            if (imem_bus.addr !== m_pc) begin
                failed++;
                $display("FAIL imem_addr_pre: got %h expected %h", imem_bus.addr, m_pc);
            end
        end
        if (r) begin
            m_pc = RESET_PC; m_instr = 0; m_pc4 = 0; m_valid = 0; m_stall = '0; m_bubble = '0;
        end else begin
            if (!a1 || !a2) m_stall = sat(m_stall);
            if (rv) begin
                m_pc = rt; m_instr = 0; m_pc4 = 0; m_valid = 0; m_bubble = sat(m_bubble);
            end else if (!a1) begin
            end else if (!a2 || !rd) begin
                m_instr = 0; m_pc4 = 0; m_valid = 0; m_bubble = sat(m_bubble);
            end else begin
                m_instr = mem_word(m_pc); m_pc4 = m_pc + 32'd4; m_valid = 1; m_pc = m_pc + 32'd4;
            end
        end
        e = '{pc: m_pc, instr: m_instr, pc4: m_pc4, valid: m_valid, stall: m_stall, bubble: m_bubble};
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        tests++;
        if (if_instr !== e.instr) begin
            failed++; $display("FAIL sb_if_instr: got %h expected %h", if_instr, e.instr);
        end
        tests++;
        if (if_pc4 !== e.pc4) begin
            failed++; $display("FAIL sb_if_pc4: got %h expected %h", if_pc4, e.pc4);
        end
        tests++;
        if (if_valid !== e.valid) begin
            failed++; $display("FAIL sb_if_valid: got %b expected %b", if_valid, e.valid);
        end
        tests++;
        if (stall_cnt !== e.stall) begin
            failed++; $display("FAIL sb_stall_cnt: got %0d expected %0d", stall_cnt, e.stall);
        end
        tests++;
        if (bubble_cnt !== e.bubble) begin
            failed++; $display("FAIL sb_bubble_cnt: got %0d expected %0d", bubble_cnt, e.bubble);
        end
        tests++;
        if (imem_bus.addr !== e.pc) begin
            failed++; $display("FAIL sb_imem_addr: got %h expected %h", imem_bus.addr, e.pc);
        end
    endtask

    task automatic fetch(input int n);
        for (int i = 0; i < n; i++) step(0, 1, 1, 0, 32'd0, 1);
    endtask

    task automatic test_reset();
        step(1, 1, 1, 0, 32'd0, 1);
        tests++;
        if (if_instr !== 32'd0 || if_pc4 !== 32'd0 || if_valid !== 1'b0) begin
            failed++;
            $display("FAIL reset_ifid: got instr=%h pc4=%h valid=%b expected 0/0/0", if_instr, if_pc4, if_valid);
        end
        tests++;
        if (stall_cnt !== '0 || bubble_cnt !== '0 || imem_bus.addr !== RESET_PC) begin
            failed++;
            $display("FAIL reset_state: got stall=%0d bubble=%0d addr=%h expected 0 0 %h",
                     stall_cnt, bubble_cnt, imem_bus.addr, RESET_PC);
        end
    endtask

    task automatic test_fetch();
        step(1, 1, 1, 0, 32'd0, 1);
        fetch(4);
        tests++;
        if (if_instr !== mem_word(32'hC) || if_pc4 !== 32'h10 || imem_bus.addr !== 32'h10) begin
            failed++;
            $display("FAIL fetch_seq: got instr=%h pc4=%h addr=%h expected %h 00000010 00000010",
                     if_instr, if_pc4, imem_bus.addr, mem_word(32'hC));
        end
    endtask

    task automatic test_s1_stall();
        step(1, 1, 1, 0, 32'd0, 1);
        fetch(2);
        step(0, 0, 1, 0, 32'd0, 1);
        step(0, 0, 0, 0, 32'd0, 1);
        tests++;
        if (if_instr !== mem_word(32'h4) || if_pc4 !== 32'h8 || imem_bus.addr !== 32'h8) begin
            failed++;
            $display("FAIL s1_hold: got instr=%h pc4=%h addr=%h expected %h 00000008 00000008",
                     if_instr, if_pc4, imem_bus.addr, mem_word(32'h4));
        end
        tests++;
        if (stall_cnt !== 4'd2 || bubble_cnt !== 4'd0) begin
            failed++;
            $display("FAIL s1_counts: got stall=%0d bubble=%0d expected 2 0", stall_cnt, bubble_cnt);
        end
    endtask

    task automatic test_s2_stall();
        step(1, 1, 1, 0, 32'd0, 1);
        fetch(1);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 32'd0, 1);
        tests++;
        if (if_valid !== 1'b0 || if_instr !== 32'd0 || imem_bus.addr !== 32'h4) begin
            failed++;
            $display("FAIL s2_bubble: got valid=%b instr=%h addr=%h expected 0 0 00000004",
                     if_valid, if_instr, imem_bus.addr);
        end
        tests++;
        if (stall_cnt !== 4'd3 || bubble_cnt !== 4'd3) begin
            failed++;
            $display("FAIL s2_counts: got stall=%0d bubble=%0d expected 3 3", stall_cnt, bubble_cnt);
        end
    endtask

    task automatic test_redirect();
        step(1, 1, 1, 0, 32'd0, 1);
        fetch(1);
        step(0, 0, 1, 1, 32'h40, 0);
        tests++;
        if (imem_bus.addr !== 32'h40 || if_valid !== 1'b0 || bubble_cnt !== 4'd1 || stall_cnt !== 4'd1) begin
            failed++;
            $display("FAIL redirect: got addr=%h valid=%b bubble=%0d stall=%0d expected 00000040 0 1 1",
                     imem_bus.addr, if_valid, bubble_cnt, stall_cnt);
        end
        fetch(1);
        tests++;
        if (if_pc4 !== 32'h44 || if_instr !== mem_word(32'h40)) begin
            failed++;
            $display("FAIL redirect_fetch: got pc4=%h instr=%h expected 00000044 %h",
                     if_pc4, if_instr, mem_word(32'h40));
        end
    endtask

    task automatic test_wrap_saturate();
        step(1, 1, 1, 0, 32'd0, 1);
        step(0, 1, 1, 1, 32'hFFFF_FFFC, 1);
        fetch(1);
        tests++;
        if (if_pc4 !== 32'd0 || imem_bus.addr !== 32'd0 || if_instr !== mem_word(32'hFFFF_FFFC)) begin
            failed++;
            $display("FAIL pc_wrap: got pc4=%h addr=%h instr=%h expected 0 0 %h",
                     if_pc4, imem_bus.addr, if_instr, mem_word(32'hFFFF_FFFC));
        end
        for (int i = 0; i < 20; i++) step(0, 1, 0, 0, 32'd0, 1);
        tests++;
        if (stall_cnt !== CMAX || bubble_cnt !== CMAX) begin
            failed++;
            $display("FAIL saturate: got stall=%0d bubble=%0d expected %0d %0d", stall_cnt, bubble_cnt, CMAX, CMAX);
        end
    endtask

    task automatic test_reset_mid_wait();
        step(1, 1, 1, 0, 32'd0, 1);
        fetch(2);
        step(0, 1, 1, 0, 32'd0, 0);
        step(0, 0, 1, 0, 32'd0, 0);
        step(1, 0, 1, 0, 32'd0, 0);
        tests++;
        if (if_instr !== 32'd0 || if_valid !== 1'b0 || stall_cnt !== '0 || bubble_cnt !== '0
            || imem_bus.addr !== RESET_PC) begin
            failed++;
            $display("FAIL reset_mid_wait: got instr=%h valid=%b stall=%0d bubble=%0d addr=%h expected all reset",
                     if_instr, if_valid, stall_cnt, bubble_cnt, imem_bus.addr);
        end
        fetch(1);
        tests++;
        if (if_pc4 !== RESET_PC + 32'd4 || if_instr !== mem_word(RESET_PC)) begin
            failed++;
            $display("FAIL resume_after_reset: got pc4=%h instr=%h expected %h %h",
                     if_pc4, if_instr, RESET_PC + 32'd4, mem_word(RESET_PC));
        end
    endtask

    task automatic test_back_to_back();
        step(1, 1, 1, 0, 32'd0, 1);
        for (int i = 0; i < 80; i++) begin
            logic a1, a2, rv, rd;
            logic [31:0] rt;
            a1 = ($urandom_range(0, 4) != 0);
            a2 = ($urandom_range(0, 4) != 0);
            rv = ($urandom_range(0, 9) == 0);
            rd = ($urandom_range(0, 3) != 0);
            rt = $urandom;
            step(0, a1, a2, rv, rt, rd);
        end
    endtask

    initial begin
        reset = 1'b1; s1 = 1'b1; s2 = 1'b1; redirect_valid = 1'b0; redirect_target = 32'd0; rdy = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_fetch();
        test_s1_stall();
        test_s2_stall();
        test_redirect();
        test_wrap_saturate();
        test_reset_mid_wait();
        test_back_to_back();
        tests++;
        if (sb.size() != 0) begin
            failed++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
